// File: rtl/spi_mcu_arbiter.sv
// spi_mcu_arbiter: round-robin owner of the shared MCU SPI link, with MCU ready edge routing to the owner.
// Optional bus watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_mcu_arbiter #(
  parameter int CLIENTS        = 2,
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               i_sclk,
  input  logic               i_nreset,
  input  logic               i_mcu_ready,
  input  logic [CLIENTS-1:0] i_req,
  input  logic [CLIENTS-1:0] i_clk_running,
  input  logic [CLIENTS-1:0] i_clk_stretch,
  input  logic [CLIENTS-1:0] i_spi_do,
  input  logic [CLIENTS-1:0] i_nsel,
  output logic [CLIENTS-1:0] o_grant,
  output logic [CLIENTS-1:0] o_ready_falling_edge,
  output logic [CLIENTS-1:0] o_timeout,
  output logic               o_clk_running,
  output logic               o_clk_stretch,
  output logic               o_spi_do,
  output logic               o_nsel
);
  localparam int PW = (CLIENTS > 2) ? 2 : 1;
  typedef enum logic [1:0] {IDLE, OWN, GUARD} state_t;
  state_t             r_state;
  logic [PW-1:0]      r_ptr, r_own, w_pick;
  logic               w_any, w_fall, w_owned, w_rel, w_expire;
  logic [3:0]         r_gcnt;
  logic [2:0]         r_sync;
  logic [CLIENTS-1:0] r_grant, r_rfe;
  // Walk downwards so the requester closest to the pointer is the last one written.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (i_req[(int'(r_ptr) + i) % CLIENTS]) begin
        w_pick = PW'((int'(r_ptr) + i) % CLIENTS);
        w_any  = 1'b1;
      end
    end
  end
  assign w_fall               = r_sync[2] & ~r_sync[1];
  assign w_owned              = |r_grant;
  assign w_rel                = ~i_req[r_own];
  assign o_grant              = r_grant;
  assign o_ready_falling_edge = r_rfe;
  assign o_nsel               = w_owned ? i_nsel[r_own] : 1'b1;
  assign o_clk_running        = w_owned ? i_clk_running[r_own] : 1'b0;
  assign o_clk_stretch        = w_owned ? i_clk_stretch[r_own] : 1'b0;
  assign o_spi_do             = w_owned ? i_spi_do[r_own] : 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [15:0]        r_wd;
  logic [CLIENTS-1:0] r_to;
  logic               w_wd_clr;
  assign w_wd_clr  = o_clk_running | (|r_rfe);
  assign w_expire  = (r_state == OWN) && !w_rel && !w_wd_clr && (r_wd == 16'(TIMEOUT_CYCLES - 1));
  assign o_timeout = r_to;
  always_ff @(posedge i_sclk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_wd <= '0;
      r_to <= '0;
    end else begin
      r_wd <= (r_state == OWN && !w_wd_clr) ? r_wd + 16'd1 : 16'd0;
      r_to <= w_expire ? r_grant : '0;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^16'(TIMEOUT_CYCLES);
  assign w_expire         = 1'b0;
  assign o_timeout        = '0;
`endif
  always_ff @(posedge i_sclk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_own   <= '0;
      r_grant <= '0;
      r_gcnt  <= '0;
      r_sync  <= 3'b111;
      r_rfe   <= '0;
    end else begin
      r_sync <= {r_sync[1:0], i_mcu_ready};
      r_rfe  <= w_fall ? r_grant : '0;
      case (r_state)
        IDLE: if (w_any) begin
          r_state <= OWN;
          r_own   <= w_pick;
          r_grant <= CLIENTS'(1) << w_pick;
          r_ptr   <= (w_pick == PW'(CLIENTS - 1)) ? '0 : w_pick + 1'b1;
        end
        OWN: if (w_rel || w_expire) begin
          r_state <= GUARD;
          r_grant <= '0;
          r_gcnt  <= '0;
        end
        GUARD: if (r_gcnt == 4'(GUARD_CYCLES - 1)) r_state <= IDLE;
               else r_gcnt <= r_gcnt + 4'd1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_mcu_arbiter.sv
// tb_spi_mcu_arbiter: randomized bench for spi_mcu_arbiter against a rule-level reference model.
module tb_spi_mcu_arbiter;
  localparam int C = 2, G = 4, T = 100;
  logic clk = 0, nrst = 0, rdy = 1;
  logic [C-1:0] req = '0, run = '0, str = '0, sdo = '1, nsel = '1;
  logic [C-1:0] gnt, rfe, to;
  logic o_run, o_str, o_sdo, o_nsel;
  int total = 0, bad = 0, m_ptr = 0;

  spi_mcu_arbiter #(.CLIENTS(C), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .i_sclk(clk), .i_nreset(nrst), .i_mcu_ready(rdy), .i_req(req),
    .i_clk_running(run), .i_clk_stretch(str), .i_spi_do(sdo), .i_nsel(nsel),
    .o_grant(gnt), .o_ready_falling_edge(rfe), .o_timeout(to),
    .o_clk_running(o_run), .o_clk_stretch(o_str), .o_spi_do(o_sdo), .o_nsel(o_nsel));

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic int pick(input logic [C-1:0] m);
    for (int i = 0; i < C; i++) if (m[(m_ptr + i) % C]) return (m_ptr + i) % C;
    return -1;
  endfunction

  function automatic logic [C-1:0] onehot(input int i);
    logic [C-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic randomize_data();
    run = C'($urandom); str = C'($urandom); sdo = C'($urandom); nsel = C'($urandom);
  endtask

  task automatic test_reset();
    nrst = 0; tick(2);
    total++; if (gnt !== '0) begin bad++; $display("FAIL rst_grant got=%b exp=0", gnt); end
    total++; if ({o_nsel, o_run, o_str, o_sdo} !== 4'b1001) begin bad++; $display("FAIL rst_outs got=%b exp=1001", {o_nsel, o_run, o_str, o_sdo}); end
    total++; if (rfe !== '0) begin bad++; $display("FAIL rst_rfe got=%b exp=0", rfe); end
    total++; if (to !== '0) begin bad++; $display("FAIL rst_timeout got=%b exp=0", to); end
    nrst = 1; m_ptr = 0; tick();
  endtask

  task automatic test_single();
    int idx;
    logic [3:0] exp;
    req = 2'b01; idx = pick(req); tick(); m_ptr = (idx + 1) % C;
    total++; if (gnt !== onehot(idx)) begin bad++; $display("FAIL single_grant got=%b exp=%b", gnt, onehot(idx)); end
    for (int k = 0; k < 8; k++) begin
      randomize_data(); #1;
      exp = {nsel[idx], run[idx], str[idx], sdo[idx]};
      total++; if ({o_nsel, o_run, o_str, o_sdo} !== exp) begin bad++; $display("FAIL single_mux got=%b exp=%b", {o_nsel, o_run, o_str, o_sdo}, exp); end
      tick();
    end
    req = '0; tick();
    total++; if (gnt !== '0 || o_nsel !== 1'b1) begin bad++; $display("FAIL single_release grant=%b nsel=%b exp 0/1", gnt, o_nsel); end
    req = 2'b01;
    for (int k = 0; k < G; k++) begin
      tick();
      total++; if (gnt !== '0 || o_nsel !== 1'b1) begin bad++; $display("FAIL single_guard%0d grant=%b nsel=%b exp 0/1", k, gnt, o_nsel); end
    end
    idx = pick(req); tick(); m_ptr = (idx + 1) % C;
    total++; if (gnt !== onehot(idx)) begin bad++; $display("FAIL single_regrant got=%b exp=%b", gnt, onehot(idx)); end
    req = '0; tick(); tick(G);
  endtask

  task automatic test_round_robin();
    int idx;
    logic [3:0] exp;
    for (int it = 0; it < 20; it++) begin
      req = C'($urandom_range(1, (1 << C) - 1));
      if (it == 0) req = '1;
      if (it > 0)
        for (int k = 0; k < G; k++) begin
          tick();
          total++; if (gnt !== '0) begin bad++; $display("FAIL rr_guard it=%0d k=%0d got=%b exp=0", it, k, gnt); end
        end
      idx = pick(req); tick(); m_ptr = (idx + 1) % C;
      total++; if (gnt !== onehot(idx)) begin bad++; $display("FAIL rr_grant it=%0d req=%b got=%b exp=%b", it, req, gnt, onehot(idx)); end
      for (int k = 0; k < 3; k++) begin
        req = C'($urandom) | onehot(idx); randomize_data(); tick();
        exp = {nsel[idx], run[idx], str[idx], sdo[idx]};
        total++; if (gnt !== onehot(idx)) begin bad++; $display("FAIL rr_hold it=%0d got=%b exp=%b", it, gnt, onehot(idx)); end
        total++; if ({o_nsel, o_run, o_str, o_sdo} !== exp) begin bad++; $display("FAIL rr_mux it=%0d got=%b exp=%b", it, {o_nsel, o_run, o_str, o_sdo}, exp); end
      end
      req = '0; tick();
      total++; if (gnt !== '0 || o_nsel !== 1'b1) begin bad++; $display("FAIL rr_release it=%0d grant=%b nsel=%b", it, gnt, o_nsel); end
    end
    run = '0; tick(G);
  endtask

  task automatic test_ready();
    int own;
    for (int it = 0; it < 6; it++) begin
      own = $urandom_range(0, C - 1); req = onehot(own); tick(); m_ptr = (own + 1) % C;
      total++; if (gnt !== onehot(own)) begin bad++; $display("FAIL rdy_grant it=%0d got=%b exp=%b", it, gnt, onehot(own)); end
      rdy = 0;
      for (int k = 1; k <= 2; k++) begin
        tick();
        total++; if (rfe !== '0) begin bad++; $display("FAIL rdy_early it=%0d edge=%0d got=%b exp=0", it, k, rfe); end
      end
      if (it % 2 == 1) req = '0;
      tick();
      total++; if (rfe !== onehot(own)) begin bad++; $display("FAIL rdy_pulse it=%0d got=%b exp=%b", it, rfe, onehot(own)); end
      tick();
      total++; if (rfe !== '0) begin bad++; $display("FAIL rdy_one_cycle it=%0d got=%b exp=0", it, rfe); end
      tick(1); rdy = 1; tick(3);
      req = '0; tick(); tick(G);
    end
    rdy = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (rfe !== '0) begin bad++; $display("FAIL rdy_idle k=%0d got=%b exp=0", k, rfe); end
    end
    rdy = 1; tick(3);
  endtask

  task automatic test_reset_mid();
    req = 2'b10; nsel = 2'b01; run = 2'b10; tick(); m_ptr = 0;
    total++; if (gnt !== 2'b10 || o_nsel !== 1'b0) begin bad++; $display("FAIL mid_grant grant=%b nsel=%b exp 10/0", gnt, o_nsel); end
    tick(2); #2 nrst = 0; #1;
    total++; if (gnt !== '0 || o_nsel !== 1'b1 || o_run !== 1'b0) begin bad++; $display("FAIL mid_async grant=%b nsel=%b run=%b exp 00/1/0", gnt, o_nsel, o_run); end
    tick(); nrst = 1; m_ptr = 0; tick();
    total++; if (gnt !== 2'b10 || o_nsel !== 1'b0) begin bad++; $display("FAIL mid_regrant grant=%b nsel=%b exp 10/0", gnt, o_nsel); end
    m_ptr = 0; run = '0; nsel = '1; req = '0; tick(); tick(G);
  endtask

  task automatic test_timeout();
    int n;
    run = '0; req = 2'b01; tick(); m_ptr = 1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL to_grant got=%b exp=01", gnt); end
`ifdef SPI_ARB_TIMEOUT_EN
    n = 0;
    while (to === '0 && n < T + 20) begin tick(); n++; end
    total++; if (n !== T) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", n, T); end
    total++; if (to !== 2'b01 || gnt !== '0) begin bad++; $display("FAIL to_pulse timeout=%b grant=%b exp 01/00", to, gnt); end
    tick();
    total++; if (to !== '0) begin bad++; $display("FAIL to_one_cycle got=%b exp=0", to); end
`else
    n = 0;
    repeat (T + 50) begin tick(); if (gnt !== 2'b01 || to !== '0) n++; end
    total++; if (n !== 0) begin bad++; $display("FAIL to_hold lost_cycles got=%0d exp=0", n); end
`endif
    req = '0; tick(); tick(G + 2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog bench did not finish got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ready();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
